// File: rtl/noc_out_port_arbiter.sv
// Output-port switch allocator for the 5-port wormhole router: round-robin
// arbitration with a wormhole lock until the tail flit transfers.
// Optional watchdog (forced release of a stalled lock) enabled by defining NOC_ARB_WATCHDOG_EN.
module noc_out_port_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] req,
  input  logic [4:0] req_tail,
  input  logic       out_ready,
  output logic [4:0] grant,
  output logic [4:0] pop,
  output logic       fire,
  output logic       busy,
  output logic       timeout_err
);

  // Handshake: a flit moves on a cycle where the locked input requests
  // (req[g]) and downstream is ready (out_ready); pop strobes that input.
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [2:0] g_idx;
  logic [2:0] win_idx;
  logic       win_found;
  logic [3:0] cand;
  logic [2:0] next_ptr;

  assign fire     = |(grant & req) & out_ready;
  assign pop      = grant & {5{fire}};
  assign next_ptr = (g_idx == 3'd4) ? 3'd0 : g_idx + 3'd1;

  // First requester in the order ptr, ptr+1, ... wrapping mod 5.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr;
    cand      = 4'd0;
    for (int k = 0; k < 5; k++) begin
      cand = {1'b0, ptr} + 4'(k);
      if (cand >= 4'd5) cand = cand - 4'd5;
      if (!win_found && req[cand[2:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[2:0];
      end
    end
  end

`ifdef NOC_ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= 5'b00000;
      busy  <= 1'b0;
      ptr   <= 3'd4;
      g_idx <= 3'd0;
`ifdef NOC_ARB_WATCHDOG_EN
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
`ifdef NOC_ARB_WATCHDOG_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (win_found) begin
            state <= LOCKED;
            grant <= 5'b00001 << win_idx;
            g_idx <= win_idx;
            busy  <= 1'b1;
`ifdef NOC_ARB_WATCHDOG_EN
            wd_cnt <= '0;
`endif
          end
        end
        LOCKED: begin
          if (fire) begin
`ifdef NOC_ARB_WATCHDOG_EN
            wd_cnt <= '0;
`endif
            if (req_tail[g_idx]) begin
              state <= IDLE;
              grant <= 5'b00000;
              busy  <= 1'b0;
              ptr   <= next_ptr;
            end
          end
`ifdef NOC_ARB_WATCHDOG_EN
          // Stalled too long: drop the lock and skip the stalled input.
          else if (wd_cnt == CW'(TIMEOUT)) begin
            state       <= IDLE;
            grant       <= 5'b00000;
            busy        <= 1'b0;
            ptr         <= next_ptr;
            wd_cnt      <= '0;
            timeout_err <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        default: begin
          state <= IDLE;
          grant <= 5'b00000;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef NOC_ARB_WATCHDOG_EN
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_noc_out_port_arbiter.sv
// Scoreboard bench for noc_out_port_arbiter: directed scenarios plus random
// traffic, checked cycle by cycle against a packet-level reference model.
module tb_noc_out_port_arbiter;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] req;
  logic [4:0] req_tail;
  logic       out_ready;
  logic [4:0] grant;
  logic [4:0] pop;
  logic       fire;
  logic       busy;
  logic       timeout_err;

  noc_out_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_tail(req_tail),
    .out_ready(out_ready), .grant(grant), .pop(pop), .fire(fire),
    .busy(busy), .timeout_err(timeout_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Reference model: packet-level view of the port.
  bit m_locked;
  int m_g;
  int m_ptr;
  int m_cnt;
  bit m_terr;

  int vectors = 0;
  int miscompares = 0;
  logic [12:0] exp_q[$];

  task automatic model_reset();
    m_locked = 0; m_g = 0; m_ptr = 4; m_cnt = 0; m_terr = 0;
  endtask

  function automatic logic [12:0] model_outputs(input logic [4:0] r, input logic o);
    logic [4:0] g;
    logic       f;
    g = m_locked ? 5'(1 << m_g) : 5'b00000;
    f = m_locked && r[m_g] && o;
    return {g, f ? g : 5'b00000, f, m_locked, m_terr};
  endfunction

  task automatic model_edge(input logic [4:0] r, input logic [4:0] t, input logic o);
    m_terr = 0;
    if (!m_locked) begin
      for (int k = 0; k < 5; k++) begin
        if (!m_locked && r[(m_ptr + k) % 5]) begin
          m_locked = 1;
          m_g      = (m_ptr + k) % 5;
          m_cnt    = 0;
        end
      end
    end else if (r[m_g] && o) begin
      m_cnt = 0;
      if (t[m_g]) begin
        m_locked = 0;
        m_ptr    = (m_g + 1) % 5;
      end
    end else begin
`ifdef NOC_ARB_WATCHDOG_EN
      if (m_cnt == TO) begin
        m_locked = 0;
        m_ptr    = (m_g + 1) % 5;
        m_cnt    = 0;
        m_terr   = 1;
      end else begin
        m_cnt++;
      end
`endif
    end
  endtask

  // driver: one cycle of stimulus, expectation pushed before sampling
  task automatic step(input logic [4:0] r, input logic [4:0] t, input logic o, input logic rs);
    @(negedge clk);
    req = r; req_tail = t; out_ready = o; rst = rs;
    if (rs) model_reset();
    exp_q.push_back(model_outputs(r, o));
    if (!rs) model_edge(r, t, o);
  endtask

  // monitor: pops and compares away from the rising edge
  logic [12:0] act;
  logic [12:0] e;
  always begin
    @(negedge clk);
    #2;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {grant, pop, fire, busy, timeout_err};
      vectors++;
      if (act !== e) begin
        miscompares++;
        $display("FAIL cycle_check t=%0t req=%b tail=%b rdy=%b: got grant=%b pop=%b fire=%b busy=%b terr=%b, want grant=%b pop=%b fire=%b busy=%b terr=%b",
                 $time, req, req_tail, out_ready, act[12:8], act[7:3], act[2], act[1], act[0],
                 e[12:8], e[7:3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    model_reset();
    req = '0; req_tail = '0; out_ready = 1'b0; rst = 1'b1;
    step(5'b00000, 5'b00000, 1'b0, 1'b1);
    step(5'b00000, 5'b00000, 1'b0, 1'b1);

    // round robin with single-flit packets
    for (int i = 0; i < 16; i++) step(5'b11111, 5'b11111, 1'b1, 1'b0);

    // mid-packet reset with everything requesting, then Local wins first
    for (int i = 0; i < 3; i++) step(5'b11111, 5'b00000, 1'b1, 1'b0);
    step(5'b11111, 5'b00000, 1'b1, 1'b1);
    step(5'b11111, 5'b00000, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(5'b11111, 5'b11111, 1'b1, 1'b0);

    // wormhole lock on North with a bubble and back-pressure, South waiting
    step(5'b00000, 5'b00000, 1'b0, 1'b1);
    step(5'b00100, 5'b00000, 1'b1, 1'b0);
    step(5'b00101, 5'b00000, 1'b1, 1'b0);
    step(5'b00101, 5'b00000, 1'b1, 1'b0);
    step(5'b00101, 5'b00000, 1'b0, 1'b0);
    step(5'b00001, 5'b00000, 1'b1, 1'b0);
    step(5'b00101, 5'b00000, 1'b1, 1'b0);
    step(5'b00101, 5'b00100, 1'b0, 1'b0);
    step(5'b00101, 5'b00100, 1'b0, 1'b0);
    step(5'b00101, 5'b00100, 1'b0, 1'b0);
    step(5'b00101, 5'b00100, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(5'b00001, 5'b00001, 1'b1, 1'b0);

    // pointer wrap: Local then South
    step(5'b00000, 5'b00000, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(5'b10001, 5'b10001, 1'b1, 1'b0);

    // long stall on East
    step(5'b00000, 5'b00000, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) step(5'b00010, 5'b00000, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(5'b11111, 5'b11111, 1'b1, 1'b0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      logic [4:0] r, t;
      logic o, rs;
      r  = 5'($urandom_range(0, 31));
      t  = 5'($urandom_range(0, 31)) & 5'($urandom_range(0, 31));
      o  = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0) o = 1'b0;
      step(r, t, o, rs);
    end

    @(negedge clk);
    #5;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
